cbfp_index_buffer: RTL and testbench

CBFP_INDEX_BUFFER -- requirements
Module: cbfp_index_buffer

---
 rtl/cbfp_index_buffer.sv | 154 +++++++++++++++
 tb/tb_cbfp_index_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_index_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cbfp_index_buffer                                          |
// | Description : Ping-pong buffer for CBFP stage-1 shift indices; adds the   |
// |               stage-2 index on readout and flags block boundaries.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cbfp_index_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int CNT_W      = 5
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_wr_en,
    input  logic [DATA_WIDTH*CNT_W-1:0]       i_cnt1,
    input  logic                              i_rd_en,
    input  logic [DATA_WIDTH*CNT_W-1:0]       i_cnt2,
    output logic [DATA_WIDTH*(CNT_W+1)-1:0]   o_idx_sum,
    output logic                              o_valid,
    output logic                              o_blk_done,
    output logic [1:0]                        o_full,
    output logic                              o_ovf,
    output logic                              o_udf
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = DATA_WIDTH * CNT_W;
    localparam int LANE_W = CNT_W + 1;
    localparam int SUM_W  = DATA_WIDTH * LANE_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Index storage carries no reset; only control state is initialised.
    logic [WORD_W-1:0] mem_q [2][DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             valid_q, valid_d;
    logic             blk_done_q, blk_done_d;
    logic [SUM_W-1:0] idx_sum_q, idx_sum_d;

    logic              w_wr_blocked;
    logic              w_wr_ok;
    logic              w_wr_last;
    logic              w_rd_ok;
    logic              w_rd_last;
    logic [WORD_W-1:0] w_rd_word;
    logic [SUM_W-1:0]  w_sum;

    assign w_wr_blocked = full_q[wr_bank_q];
    assign w_wr_ok      = i_wr_en & ~w_wr_blocked;
    assign w_wr_last    = (wr_ptr_q == LAST_PTR);
    // Read qualification uses the pre-edge full flag, so a block that
    // completes on this edge cannot be read until the following cycle.
    assign w_rd_ok      = i_rd_en & full_q[rd_bank_q];
    assign w_rd_last    = (rd_ptr_q == LAST_PTR);
    assign w_rd_word    = mem_q[rd_bank_q][rd_ptr_q];

    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_lane
        assign w_sum[k*LANE_W +: LANE_W] = {1'b0, w_rd_word[k*CNT_W +: CNT_W]}
                                         + {1'b0, i_cnt2[k*CNT_W +: CNT_W]};
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[wr_bank_q][wr_ptr_q] <= i_cnt1;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        rd_ptr_d   = rd_ptr_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        valid_d    = 1'b0;
        blk_done_d = 1'b0;
        idx_sum_d  = idx_sum_q;

        if (w_wr_ok) begin
            if (w_wr_last) begin
                wr_ptr_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end
        if (i_wr_en && w_wr_blocked) begin
            ovf_d = 1'b1;
        end

        // Write and read never target the same bank on one edge: a write
        // needs its bank empty, a read needs its bank full.
        if (w_rd_ok) begin
            valid_d   = 1'b1;
            idx_sum_d = w_sum;
            if (w_rd_last) begin
                rd_ptr_d          = '0;
                rd_bank_d         = ~rd_bank_q;
                full_d[rd_bank_q] = 1'b0;
                blk_done_d        = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
        if (i_rd_en && !w_rd_ok) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            valid_q    <= 1'b0;
            blk_done_q <= 1'b0;
            idx_sum_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            valid_q    <= valid_d;
            blk_done_q <= blk_done_d;
            idx_sum_q  <= idx_sum_d;
        end
    end

    assign o_idx_sum  = idx_sum_q;
    assign o_valid    = valid_q;
    assign o_blk_done = blk_done_q;
    assign o_full     = full_q;
    assign o_ovf      = ovf_q;
    assign o_udf      = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_cbfp_index_buffer.sv
`default_nettype none
// Testbench for cbfp_index_buffer: block-FIFO reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cbfp_index_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int CW    = 5;
    localparam int SLW   = CW + 1;
    localparam int WW    = DW * CW;
    localparam int SW    = DW * SLW;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          wr_en  = 1'b0;
    logic          rd_en  = 1'b0;
    logic [WW-1:0] cnt1   = '0;
    logic [WW-1:0] cnt2   = '0;
    logic [SW-1:0] idx_sum;
    logic          valid;
    logic          blk_done;
    logic [1:0]    full;
    logic          ovf;
    logic          udf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cbfp_index_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_wr_en    (wr_en),
        .i_cnt1     (cnt1),
        .i_rd_en    (rd_en),
        .i_cnt2     (cnt2),
        .o_idx_sum  (idx_sum),
        .o_valid    (valid),
        .o_blk_done (blk_done),
        .o_full     (full),
        .o_ovf      (ovf),
        .o_udf      (udf)
    );

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] vec_k(input int off);
        logic [WW-1:0] v;
        for (int k = 0; k < DW; k++) v[k*CW +: CW] = CW'((k + off) % 32);
        return v;
    endfunction

    function automatic logic [WW-1:0] vec_fill(input int val);
        logic [WW-1:0] v;
        for (int k = 0; k < DW; k++) v[k*CW +: CW] = CW'(val);
        return v;
    endfunction

    function automatic logic [SW-1:0] sum_k(input int off, input int add);
        logic [SW-1:0] v;
        for (int k = 0; k < DW; k++) v[k*SLW +: SLW] = SLW'(((k + off) % 32) + add);
        return v;
    endfunction

    function automatic logic [SW-1:0] sum_fill(input int val);
        logic [SW-1:0] v;
        for (int k = 0; k < DW; k++) v[k*SLW +: SLW] = SLW'(val);
        return v;
    endfunction

    // Reference model: written words form one stream; completed blocks are
    // queued with the bank they landed in. At most two blocks may be pending.
    logic [WW-1:0] m_words[$];
    int            m_pend_bank[$];
    int            m_wr_cnt = 0;
    int            m_rd_cnt = 0;
    int            m_wr_par = 0;
    logic [SW-1:0] e_sum   = '0;
    logic          e_valid = 1'b0;
    logic          e_done  = 1'b0;
    logic          e_ovf   = 1'b0;
    logic          e_udf   = 1'b0;
    logic [1:0]    e_full  = 2'b00;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_words.delete();
            m_pend_bank.delete();
            m_wr_cnt = 0;
            m_rd_cnt = 0;
            m_wr_par = 0;
            e_sum    = '0;
            e_valid  = 1'b0;
            e_done   = 1'b0;
            e_ovf    = 1'b0;
            e_udf    = 1'b0;
            e_full   = 2'b00;
        end else begin
            bit            can_rd;
            bit            can_wr;
            logic [WW-1:0] w;
            can_rd  = (m_pend_bank.size() > 0);
            can_wr  = (m_pend_bank.size() < 2);
            e_valid = 1'b0;
            e_done  = 1'b0;
            if (rd_en) begin
                if (can_rd) begin
                    w = m_words.pop_front();
                    for (int k = 0; k < DW; k++)
                        e_sum[k*SLW +: SLW] = SLW'(w[k*CW +: CW]) + SLW'(cnt2[k*CW +: CW]);
                    e_valid = 1'b1;
                    m_rd_cnt++;
                    if (m_rd_cnt == DEPTH) begin
                        m_rd_cnt = 0;
                        e_done   = 1'b1;
                        void'(m_pend_bank.pop_front());
                    end
                end else begin
                    e_udf = 1'b1;
                end
            end
            if (wr_en) begin
                if (can_wr) begin
                    m_words.push_back(cnt1);
                    m_wr_cnt++;
                    if (m_wr_cnt == DEPTH) begin
                        m_pend_bank.push_back(m_wr_par);
                        m_wr_par = 1 - m_wr_par;
                        m_wr_cnt = 0;
                    end
                end else begin
                    e_ovf = 1'b1;
                end
            end
            e_full = 2'b00;
            foreach (m_pend_bank[i]) e_full[m_pend_bank[i]] = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rstn) begin
            chk("m_valid",    valid,    e_valid);
            chk("m_blk_done", blk_done, e_done);
            chk("m_full",     full,     e_full);
            chk("m_ovf",      ovf,      e_ovf);
            chk("m_udf",      udf,      e_udf);
            chk("m_idx_sum",  idx_sum,  e_sum);
        end
    end

    task automatic cyc(input logic we, input logic [WW-1:0] c1,
                       input logic re, input logic [WW-1:0] c2);
        wr_en = we;
        cnt1  = c1;
        rd_en = re;
        cnt2  = c2;
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset;
        rstn  = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        do_reset;
        chk("rst_sum",   idx_sum,  '0);
        chk("rst_valid", valid,    0);
        chk("rst_done",  blk_done, 0);
        chk("rst_full",  full,     0);
        chk("rst_ovf",   ovf,      0);
        chk("rst_udf",   udf,      0);

        // Read pulse with nothing buffered, then one plain block.
        cyc(1'b0, '0, 1'b1, vec_fill(1));
        chk("udf_pulse", udf,   1);
        chk("udf_valid", valid, 0);
        for (int w = 0; w < DEPTH; w++) cyc(1'b1, vec_k(0), 1'b0, '0);
        chk("blk_full", full, 2'b01);
        for (int w = 0; w < DEPTH; w++) begin
            cyc(1'b0, '0, 1'b1, vec_fill(1));
            if (w == 0)  chk("sum_k_plus1", idx_sum, sum_k(0, 1));
            if (w == 30) chk("no_early_done", blk_done, 0);
        end
        chk("done_last",    blk_done, 1);
        chk("full_cleared", full,     2'b00);

        // Gapped write of maximal indices; maximal sum.
        do_reset;
        for (int w = 0; w < DEPTH; w++) begin
            cyc(1'b1, vec_fill(31), 1'b0, '0);
            if (w % 6 == 2) cyc(1'b0, '0, 1'b0, '0);
        end
        chk("gap_full", full, 2'b01);
        for (int w = 0; w < DEPTH; w++) begin
            cyc(1'b0, '0, 1'b1, vec_fill(31));
            if (w == 0) chk("max_sum", idx_sum, sum_fill(62));
        end
        chk("max_ovf",  ovf,  0);
        chk("max_udf",  udf,  0);
        chk("max_full", full, 2'b00);

        // Both banks filled, then an extra write that must be dropped.
        do_reset;
        for (int w = 0; w < 2 * DEPTH; w++) cyc(1'b1, vec_k(w), 1'b0, '0);
        chk("both_full", full, 2'b11);
        cyc(1'b1, vec_fill(17), 1'b0, '0);
        chk("ovf_set",       ovf,  1);
        chk("ovf_full_hold", full, 2'b11);
        for (int w = 0; w < 2 * DEPTH; w++) begin
            cyc(1'b0, '0, 1'b1, '0);
            if (w == 0)  chk("ovf_word0",  idx_sum, sum_k(0, 0));
            if (w == 63) chk("ovf_word63", idx_sum, sum_k(63, 0));
        end
        chk("ovf_drained", full, 2'b00);

        // Stream bank 1 in while bank 0 drains; final edges coincide.
        do_reset;
        for (int w = 0; w < DEPTH; w++) cyc(1'b1, vec_k(5), 1'b0, '0);
        for (int j = 0; j < DEPTH; j++) begin
            cyc(1'b1, vec_k(j), 1'b1, vec_fill(2));
            if (j == 0)  chk("stream_word0", idx_sum, sum_k(5, 2));
            if (j == 15) chk("stream_mid_full", full, 2'b01);
            if (j == 31) chk("swap_full", full, 2'b10);
        end
        for (int w = 0; w < DEPTH; w++) begin
            cyc(1'b0, '0, 1'b1, '0);
            if (w == 0) chk("bank1_word0", idx_sum, sum_k(0, 0));
            if (w == 7) chk("bank1_word7", idx_sum, sum_k(7, 0));
        end
        chk("stream_udf", udf, 0);

        // Final write and first read of the same bank on one edge.
        do_reset;
        for (int w = 0; w < DEPTH - 1; w++) cyc(1'b1, vec_fill(3), 1'b0, '0);
        cyc(1'b1, vec_fill(3), 1'b1, vec_fill(1));
        chk("same_edge_udf",   udf,   1);
        chk("same_edge_valid", valid, 0);
        chk("same_edge_full",  full,  2'b01);
        for (int w = 0; w < DEPTH; w++) begin
            cyc(1'b0, '0, 1'b1, vec_fill(1));
            if (w == 0) chk("same_edge_sum", idx_sum, sum_fill(4));
        end

        // Asynchronous reset in the middle of a block.
        for (int w = 0; w < 17; w++) cyc(1'b1, vec_k(9), 1'b0, '0);
        rstn = 1'b0;
        #1;
        chk("arst_sum",   idx_sum,  '0);
        chk("arst_valid", valid,    0);
        chk("arst_done",  blk_done, 0);
        chk("arst_full",  full,     0);
        chk("arst_udf",   udf,      0);
        chk("arst_ovf",   ovf,      0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        for (int w = 0; w < DEPTH; w++) cyc(1'b1, vec_k(11 + w), 1'b0, '0);
        chk("arst_bank0_full", full, 2'b01);
        for (int w = 0; w < DEPTH; w++) begin
            cyc(1'b0, '0, 1'b1, vec_fill(1));
            if (w == 0) chk("arst_word0", idx_sum, sum_k(11, 1));
        end
        chk("arst_done_full", full, 2'b00);

        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
